// File: rtl/row_ptr_walker.sv
// Row-pointer walker: captures a packed row-pointer vector and emits one CSR-style
// (start address, count) beat per entry over valid/ready. Option: RPW_SKIP_ZERO_EN.
module row_ptr_walker #(
    parameter int unsigned PTR_W   = 3,
    parameter int unsigned MAX_ENT = 72,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PTR_W*MAX_ENT-1:0] ptr_vec,
    input  logic [6:0]               num_ent,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_start,
    output logic [PTR_W-1:0]         out_count,
    output logic [6:0]               out_index,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf
);

    localparam int unsigned VEC_W = PTR_W * MAX_ENT;
    localparam int unsigned IDX_W = 7;
    localparam int unsigned SUM_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   num_q, num_d;
    logic [ADDR_W-1:0]  acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   num_clamp;
    logic [SUM_W-1:0]   sum;
    logic               advance;
    logic               first_nz;
    logic               next_nz;

    // The captured vector shifts down one entry per step, so the current entry is always the low slice.
    always_comb begin
        num_clamp = (num_ent > IDX_W'(MAX_ENT)) ? IDX_W'(MAX_ENT) : num_ent;
        sum       = {1'b0, acc_q} + SUM_W'(vec_q[PTR_W-1:0]);
`ifdef RPW_SKIP_ZERO_EN
        first_nz  = |ptr_vec[PTR_W-1:0];
        next_nz   = |vec_q[2*PTR_W-1:PTR_W];
        advance   = out_ready || !valid_q;
`else
        first_nz  = 1'b1;
        next_nz   = 1'b1;
        advance   = out_ready;
`endif
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        num_d   = num_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (num_ent == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        vec_d   = ptr_vec;
                        num_d   = num_clamp;
                        idx_d   = '0;
                        acc_d   = base_addr;
                        busy_d  = 1'b1;
                        valid_d = first_nz;
                    end
                end
            end
            RUN: begin
                if (advance) begin
                    acc_d = sum[ADDR_W-1:0];
                    ovf_d = ovf_q | sum[ADDR_W];
                    idx_d = idx_q + IDX_W'(1);
                    vec_d = vec_q >> PTR_W;
                    if (idx_q == num_q - IDX_W'(1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        valid_d = next_nz;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign out_start = acc_q;
    assign out_count = vec_q[PTR_W-1:0];
    assign out_index = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_row_ptr_walker.sv
// Bench for row_ptr_walker: per-cycle expected timeline built from the entry list
// and the planned out_ready pattern, compared against the DUT every cycle.
module tb_row_ptr_walker;

    localparam int unsigned PTR_W   = 3;
    localparam int unsigned MAX_ENT = 72;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned VEC_W   = PTR_W * MAX_ENT;
    localparam int          NCYC    = 1024;
`ifdef RPW_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [VEC_W-1:0]  ptr_vec = '0;
    logic [6:0]        num_ent = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_start;
    logic [PTR_W-1:0]  out_count;
    logic [6:0]        out_index;
    logic              busy;
    logic              done;
    logic              ovf;

    row_ptr_walker #(.PTR_W(PTR_W), .MAX_ENT(MAX_ENT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ptr_vec(ptr_vec), .num_ent(num_ent),
        .base_addr(base_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_start(out_start), .out_count(out_count), .out_index(out_index),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected per-cycle view; cycle 1 is the first cycle after the start edge.
    logic rdy  [NCYC];
    logic ev   [NCYC];
    int   es   [NCYC];
    int   ec   [NCYC];
    int   ei   [NCYC];
    logic eovf [NCYC];
    logic ebusy[NCYC];
    int   done_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Walk the entry list in order: zero entries (skip mode) burn one cycle, others wait for ready.
    task automatic build_model(input logic [VEC_W-1:0] vec, input int num, input int base);
        int n, acc, c, cnt;
        logic ov;
        n   = (num > int'(MAX_ENT)) ? int'(MAX_ENT) : num;
        acc = base;
        ov  = 1'b0;
        c   = 1;
        for (int k = 0; k < NCYC; k++) begin
            ev[k] = 1'b0; es[k] = 0; ec[k] = 0; ei[k] = 0; eovf[k] = 1'b0; ebusy[k] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            cnt = int'(vec[i*PTR_W +: PTR_W]);
            if (SKIP && cnt == 0) begin
                ebusy[c] = 1'b1;
                eovf[c]  = ov;
                c++;
            end else begin
                while (1) begin
                    ev[c] = 1'b1; es[c] = acc; ec[c] = cnt; ei[c] = i;
                    ebusy[c] = 1'b1; eovf[c] = ov;
                    if (rdy[c]) break;
                    c++;
                end
                c++;
                acc = acc + cnt;
                if (acc >= (1 << ADDR_W)) begin
                    acc = acc - (1 << ADDR_W);
                    ov  = 1'b1;
                end
            end
        end
        done_cyc = c;
        for (int k = c; k < NCYC; k++) eovf[k] = ov;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, " start"}, 32'(out_start), 32'd0);
        check_eq({tag, " count"}, 32'(out_count), 32'd0);
        check_eq({tag, " index"}, 32'(out_index), 32'd0);
        check_eq({tag, " busy"},  32'(busy),      32'd0);
        check_eq({tag, " done"},  32'(done),      32'd0);
        check_eq({tag, " ovf"},   32'(ovf),       32'd0);
    endtask

    // mode: 0 = always ready, 1 = ready 1,0,0 repeating, 2 = random ready plus noise on start/ptr_vec
    task automatic run_walk(input string name, input logic [VEC_W-1:0] vec, input int num,
                            input int base, input int mode, input int abort_cyc);
        for (int c = 0; c < NCYC; c++) begin
            case (mode)
                0:       rdy[c] = 1'b1;
                1:       rdy[c] = (c % 3 == 1);
                default: rdy[c] = 1'($urandom_range(0, 1));
            endcase
            if (c >= NCYC / 2) rdy[c] = 1'b1;
        end
        build_model(vec, num, base);

        @(negedge clk);
        ptr_vec   = vec;
        num_ent   = 7'(num);
        base_addr = ADDR_W'(base);
        start     = 1'b1;
        out_ready = 1'b0;

        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clk);
            start     = (mode == 2 && c < done_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (mode == 2) begin
                for (int i = 0; i < int'(MAX_ENT); i++) ptr_vec[i*PTR_W +: PTR_W] = 3'($urandom);
            end
            out_ready = rdy[c];
            if (abort_cyc != 0 && c == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check_all_zero($sformatf("%s abort", name));
                start = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_eq($sformatf("%s in-reset done", name), 32'(done), 32'd0);
                end
                rst_n = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_eq($sformatf("%s post-reset done", name), 32'(done), 32'd0);
                    check_eq($sformatf("%s post-reset valid", name), 32'(out_valid), 32'd0);
                end
                return;
            end
            check_eq($sformatf("%s c%0d valid", name, c), 32'(out_valid), 32'(ev[c]));
            check_eq($sformatf("%s c%0d busy", name, c),  32'(busy),      32'(ebusy[c]));
            check_eq($sformatf("%s c%0d done", name, c),  32'(done),      32'(c == done_cyc));
            check_eq($sformatf("%s c%0d ovf", name, c),   32'(ovf),       32'(eovf[c]));
            if (ev[c]) begin
                check_eq($sformatf("%s c%0d start", name, c), 32'(out_start), 32'(es[c]));
                check_eq($sformatf("%s c%0d count", name, c), 32'(out_count), 32'(ec[c]));
                check_eq($sformatf("%s c%0d index", name, c), 32'(out_index), 32'(ei[c]));
            end
        end
        start = 1'b0;
    endtask

    logic [VEC_W-1:0] v;
    int cnt;

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < int'(MAX_ENT); i++) v[i*PTR_W +: PTR_W] = (i < 36) ? 3'd3 : 3'd0;
        run_walk("all3", v, 36, 0, 0, 0);
        run_walk("all3_stall", v, 36, 0, 1, 0);

        v = '0;
        v[0 +: PTR_W]       = 3'd1;
        v[2*PTR_W +: PTR_W] = 3'd1;
        run_walk("one_zero_one", v, 3, 10, 0, 0);

        v = '0;
        for (int i = 0; i < 3; i++) v[i*PTR_W +: PTR_W] = 3'd3;
        run_walk("wrap", v, 3, 1020, 0, 0);

        run_walk("empty", v, 0, 5, 0, 0);

        for (int i = 0; i < int'(MAX_ENT); i++) v[i*PTR_W +: PTR_W] = 3'($urandom);
        run_walk("clamp", v, 100, 300, 0, 0);

        for (int i = 0; i < int'(MAX_ENT); i++) v[i*PTR_W +: PTR_W] = (i < 36) ? 3'd3 : 3'd0;
        run_walk("abort", v, 36, 0, 0, 6);
        run_walk("restart", v, 36, 0, 0, 0);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < int'(MAX_ENT); i++) begin
                cnt = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7));
                v[i*PTR_W +: PTR_W] = 3'(cnt);
            end
            run_walk($sformatf("rand%0d", t), v, int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 1023)), 2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
